// File: rtl/at_resp_parser_if.sv
// Byte stream from the UART receiver into the response parser, plus the
// response code / message index read back by the SMS command FSM.
interface at_resp_parser_if;
    // rx_valid qualifies rx_data for exactly one cycle per byte; there is no
    // ready, the parser accepts every strobed byte. ctrl_vld is a one-cycle
    // pulse marking a fresh ctrl value; clr is a one-cycle request.
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clr;
    logic [2:0] ctrl;
    logic       ctrl_vld;
    logic [7:0] msg_no;
    logic       busy;

    modport master (
        output rx_data, rx_valid, clr,
        input  ctrl, ctrl_vld, msg_no, busy
    );

    modport slave (
        input  rx_data, rx_valid, clr,
        output ctrl, ctrl_vld, msg_no, busy
    );
endinterface

// File: rtl/at_resp_parser.sv
// Classifies modem response lines from the UART RX stream into a 3-bit code
// and tracks the SIM slot index announced by +CMTI.
module at_resp_parser #(
    parameter int MAX_LEN = 64,
    parameter int IDLE_TO = 2_000_000
) (
    input  logic             clk,
    input  logic             rst,
    at_resp_parser_if.slave  bus,
    output logic [1:0]       o_dbg_state
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(IDLE_TO + 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_2    = LW'(2);
    localparam logic [LW-1:0] LEN_5    = LW'(5);
    localparam logic [LW-1:0] LEN_6    = LW'(6);
    localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TO - 1);

    // Keywords left-aligned in 48 bits, first character in the top byte.
    localparam logic [47:0] KW_OK   = 48'h4F4B_0000_0000;
    localparam logic [47:0] KW_ERR  = 48'h4552_524F_5200;
    localparam logic [47:0] KW_CPMS = 48'h2B43_504D_533A;
    localparam logic [47:0] KW_CMTI = 48'h2B43_4D54_493A;
    localparam logic [47:0] KW_AT   = 48'h4154_0000_0000;

    localparam int M_OK   = 0;
    localparam int M_ERR  = 1;
    localparam int M_CPMS = 2;
    localparam int M_CMTI = 3;
    localparam int M_AT   = 4;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_GT    = 8'h3E;
    localparam logic [7:0] CH_COMMA = 8'h2C;

    typedef enum logic [1:0] {
        LINE_START = 2'd0,
        IN_LINE    = 2'd1,
        CMTI_IDX   = 2'd2,
        DISCARD    = 2'd3
    } state_t;

    state_t          r_state;
    logic [LW-1:0]   r_len;
    logic [4:0]      r_match;
    logic [7:0]      r_digit;
    logic            r_has_dig;
    logic            r_ovf;
    logic [TW-1:0]   r_idle;
    logic            r_emit;
    logic [2:0]      r_code;
    logic            r_load;
    logic [2:0]      r_ctrl;
    logic            r_ctrl_vld;
    logic [7:0]      r_msg_no;

    logic [7:0]      w_byte;
    logic            w_busy;
    logic            w_is_digit;
    logic [4:0]      w_first;
    logic [4:0]      w_next;

    // A flag survives a byte if it matches the keyword at that position;
    // past the keyword end, prefix keywords stay matched, exact ones drop.
    function automatic logic kw_step(input logic flag, input logic [47:0] kw,
                                     input int klen, input logic prefix,
                                     input int pos, input logic [7:0] b);
        logic [47:0] s;
        s = kw << (8 * pos);
        if (pos < klen) kw_step = flag && (b == s[47:40]);
        else            kw_step = flag && prefix;
    endfunction

    assign w_byte     = bus.rx_data;
    assign w_busy     = (r_state != LINE_START);
    assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);

    always_comb begin
        w_first = '0;
        w_next  = '0;
        w_first[M_OK]   = kw_step(1'b1, KW_OK,   2, 1'b0, 0, w_byte);
        w_first[M_ERR]  = kw_step(1'b1, KW_ERR,  5, 1'b0, 0, w_byte);
        w_first[M_CPMS] = kw_step(1'b1, KW_CPMS, 6, 1'b1, 0, w_byte);
        w_first[M_CMTI] = kw_step(1'b1, KW_CMTI, 6, 1'b1, 0, w_byte);
        w_first[M_AT]   = kw_step(1'b1, KW_AT,   2, 1'b1, 0, w_byte);
        w_next[M_OK]    = kw_step(r_match[M_OK],   KW_OK,   2, 1'b0, int'(r_len), w_byte);
        w_next[M_ERR]   = kw_step(r_match[M_ERR],  KW_ERR,  5, 1'b0, int'(r_len), w_byte);
        w_next[M_CPMS]  = kw_step(r_match[M_CPMS], KW_CPMS, 6, 1'b1, int'(r_len), w_byte);
        w_next[M_CMTI]  = kw_step(r_match[M_CMTI], KW_CMTI, 6, 1'b1, int'(r_len), w_byte);
        w_next[M_AT]    = kw_step(r_match[M_AT],   KW_AT,   2, 1'b1, int'(r_len), w_byte);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= LINE_START;
            r_len      <= '0;
            r_match    <= '0;
            r_digit    <= 8'h30;
            r_has_dig  <= 1'b0;
            r_ovf      <= 1'b0;
            r_idle     <= '0;
            r_emit     <= 1'b0;
            r_code     <= 3'b000;
            r_load     <= 1'b0;
            r_ctrl     <= 3'b000;
            r_ctrl_vld <= 1'b0;
            r_msg_no   <= 8'h30;
        end else begin
            // Output stage: a decision made at edge N is published at N+1.
            r_ctrl_vld <= r_emit;
            if (r_emit) begin
                r_ctrl <= r_code;
                if (r_load) r_msg_no <= r_digit;
            end else if (bus.clr) begin
                r_ctrl <= 3'b000;
            end
            r_emit <= 1'b0;
            r_load <= 1'b0;

            if (bus.rx_valid) begin
                r_idle <= '0;
            end else if (w_busy) begin
                if (r_idle == IDLE_LAST) begin
                    r_state <= LINE_START;
                    r_idle  <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end

            if (bus.rx_valid) begin
                case (r_state)
                    LINE_START: begin
                        if (w_byte == CH_GT) begin
                            r_emit <= 1'b1;
                            r_code <= 3'b101;
                        end else if (w_byte != CH_CR && w_byte != CH_LF && w_byte != CH_SP) begin
                            r_state   <= IN_LINE;
                            r_len     <= LW'(1);
                            r_match   <= w_first;
                            r_has_dig <= 1'b0;
                            r_ovf     <= 1'b0;
                        end
                    end
                    IN_LINE: begin
                        if (w_byte == CH_CR) begin
                            r_state <= LINE_START;
                            if (r_match[M_OK] && r_len == LEN_2) begin
                                r_emit <= 1'b1;
                                r_code <= 3'b001;
                            end else if (r_match[M_ERR] && r_len == LEN_5) begin
                                r_emit <= 1'b1;
                                r_code <= 3'b011;
                            end else if (r_match[M_CPMS] && r_len >= LEN_6) begin
                                r_emit <= 1'b1;
                                r_code <= 3'b010;
                            end else if (r_match[M_CMTI] && r_len >= LEN_6) begin
                                r_emit <= 1'b1;
                                r_code <= 3'b111;
                            end else if (!(r_match[M_AT] && r_len >= LEN_2)) begin
                                r_emit <= 1'b1;
                                r_code <= 3'b110;
                            end
                        end else if (r_len == LEN_MAX) begin
                            r_state <= DISCARD;
                        end else if (w_byte == CH_COMMA && r_match[M_CMTI] && r_len >= LEN_6) begin
                            r_state <= CMTI_IDX;
                        end else begin
                            r_len   <= r_len + 1'b1;
                            r_match <= w_next;
                        end
                    end
                    CMTI_IDX: begin
                        if (w_byte == CH_CR) begin
                            r_state <= LINE_START;
                            r_emit  <= 1'b1;
                            if (r_has_dig && !r_ovf) begin
                                r_code <= 3'b100;
                                r_load <= 1'b1;
                            end else begin
                                r_code <= 3'b111;
                            end
                        end else if (w_is_digit) begin
                            if (!r_has_dig) begin
                                r_digit   <= w_byte;
                                r_has_dig <= 1'b1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    DISCARD: begin
                        if (w_byte == CH_CR) begin
                            r_state <= LINE_START;
                            r_emit  <= 1'b1;
                            r_code  <= 3'b110;
                        end
                    end
                    default: r_state <= LINE_START;
                endcase
            end
        end
    end

    assign bus.ctrl     = r_ctrl;
    assign bus.ctrl_vld = r_ctrl_vld;
    assign bus.msg_no   = r_msg_no;
    assign bus.busy     = w_busy;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_at_resp_parser.sv
// Bench for at_resp_parser: line-level reference model feeding an expected
// queue, with an independent monitor popping on every ctrl_vld pulse.
module tb_at_resp_parser;
    localparam int MAX_LEN = 64;
    localparam int TB_IDLE = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    at_resp_parser_if dut_if();

    at_resp_parser #(.MAX_LEN(MAX_LEN), .IDLE_TO(TB_IDLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (dut_if),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard: {due cycle, code, msg_no}
    logic [42:0] exp_q[$];
    logic [7:0]  line[$];
    logic [7:0]  pkt[$];
    bit          in_line = 0;
    bit          last_emit = 0;
    logic [2:0]  exp_ctrl = 3'b000;
    logic [7:0]  exp_msg = 8'h30;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model, working on whole lines
    function automatic bit starts_with(input string s);
        logic [7:0] c;
        if (line.size() < s.len()) return 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (line[i] != c) return 0;
        end
        return 1;
    endfunction

    function automatic bit is_exact(input string s);
        return (line.size() == s.len()) && starts_with(s);
    endfunction

    task automatic push_exp(input logic [2:0] code, input logic [7:0] msg, input int due);
        logic [31:0] dv;
        dv = due;
        exp_q.push_back({dv, code, msg});
        exp_ctrl  = code;
        exp_msg   = msg;
        last_emit = 1;
    endtask

    task automatic model_eol(input int due);
        int n, comma, nd;
        logic [7:0] d;
        n = line.size(); comma = -1; nd = 0; d = 8'h00;
        if (starts_with("+CMTI:")) begin
            for (int i = 6; i < n; i++) begin
                if (line[i] == 8'h2C) begin
                    comma = i;
                    break;
                end
            end
        end
        if (comma >= 0 && comma < MAX_LEN) begin
            for (int i = comma + 1; i < n; i++) begin
                if (line[i] >= 8'h30 && line[i] <= 8'h39) begin
                    if (nd == 0) d = line[i];
                    nd++;
                end
            end
            if (nd == 1) push_exp(3'b100, d, due);
            else         push_exp(3'b111, exp_msg, due);
        end else if (n > MAX_LEN)          push_exp(3'b110, exp_msg, due);
        else if (is_exact("OK"))           push_exp(3'b001, exp_msg, due);
        else if (is_exact("ERROR"))        push_exp(3'b011, exp_msg, due);
        else if (starts_with("+CPMS:"))    push_exp(3'b010, exp_msg, due);
        else if (starts_with("+CMTI:"))    push_exp(3'b111, exp_msg, due);
        else if (!starts_with("AT"))       push_exp(3'b110, exp_msg, due);
    endtask

    task automatic model_byte(input logic [7:0] b, input int due);
        if (!in_line) begin
            if (b == 8'h3E) push_exp(3'b101, exp_msg, due);
            else if (b != 8'h0A && b != 8'h0D && b != 8'h20) begin
                in_line = 1;
                line.delete();
                line.push_back(b);
            end
        end else if (b == 8'h0D) begin
            model_eol(due);
            in_line = 0;
            line.delete();
        end else begin
            line.push_back(b);
        end
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input logic with_clr);
        @(posedge clk); #1;
        dut_if.rx_data  = b;
        dut_if.rx_valid = 1'b1;
        dut_if.clr      = with_clr;
        last_emit = 0;
        model_byte(b, cyc + 2);
        if (with_clr && !last_emit) exp_ctrl = 3'b000;
        @(posedge clk); #1;
        dut_if.rx_valid = 1'b0;
        dut_if.clr      = 1'b0;
    endtask

    task automatic send_pkt(input bit clr_last);
        for (int i = 0; i < pkt.size(); i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_byte(pkt[i], clr_last && (i == pkt.size() - 1));
        end
        pkt.delete();
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) pkt.push_back(s[i]);
    endtask

    task automatic send_str(input string s, input bit clr_last);
        add_str(s);
        send_pkt(clr_last);
    endtask

    task automatic add_junk(input int n);
        string cs;
        cs = "OKERAT+CMPSI:, 09x>\"";
        for (int i = 0; i < n; i++) pkt.push_back(cs[$urandom_range(0, cs.len() - 1)]);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        dut_if.clr = 1'b1;
        @(posedge clk); #1;
        dut_if.clr = 1'b0;
        exp_ctrl = 3'b000;
    endtask

    task automatic drain(input string tag);
        repeat (4) @(posedge clk);
        #2;
        check({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_ctrl"}, dut_if.ctrl, exp_ctrl);
        check({tag, "_msg_no"}, dut_if.msg_no, exp_msg);
        check({tag, "_busy"}, dut_if.busy, in_line);
    endtask

    // monitor
    always @(negedge clk) begin
        logic [42:0] e;
        if (rst === 1'b1 && dut_if.ctrl_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_vld: actual ctrl=%0b, required no pulse (t=%0t)", dut_if.ctrl, $time);
            end else begin
                e = exp_q.pop_front();
                check("vld_cycle", cyc, e[42:11]);
                check("ctrl", dut_if.ctrl, e[10:8]);
                check("msg_no", dut_if.msg_no, e[7:0]);
            end
        end
    end

    // stimulus
    initial begin
        int kind, n;
        rst = 1'b0;
        dut_if.rx_data  = 8'h00;
        dut_if.rx_valid = 1'b0;
        dut_if.clr      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", dut_if.ctrl, 3'b000);
        check("rst_vld", dut_if.ctrl_vld, 1'b0);
        check("rst_msg_no", dut_if.msg_no, 8'h30);
        check("rst_busy", dut_if.busy, 1'b0);
        rst = 1'b1;

        send_str("\r\nOK\r\n", 0);                  drain("ok");
        send_str("+CMTI: \"SM\",3\r\n", 0);         drain("cmti3");
        send_str("+CMTI: \"SM\",12\r", 0);          drain("cmti12");
        send_str("AT+CMGD=1,4\r", 0);               drain("echo");
        send_str("OK\r", 0);                        drain("ok_after_echo");
        send_str("+CPMS: 0,30\r", 0);               drain("cpms");
        send_str("ERROR\r", 0);                     drain("error");
        send_str("> ", 0);                          drain("prompt");
        pulse_clr();                                drain("clr");
        send_str("OK\r", 1);                        drain("clr_vs_emit");

        for (int i = 0; i < 70; i++) pkt.push_back(8'h5A);
        send_pkt(0);                                drain("long_busy");
        send_str("\r", 0);                          drain("long_cr");
        send_str("OK\r", 0);                        drain("ok_after_long");

        add_str("+CPMS:");
        while (pkt.size() < MAX_LEN) pkt.push_back(8'h78);
        add_str("\r");
        send_pkt(0);                                drain("cpms_len_max");
        add_str("+CPMS:");
        while (pkt.size() < MAX_LEN + 1) pkt.push_back(8'h78);
        add_str("\r");
        send_pkt(0);                                drain("cpms_len_over");

        send_str("O", 0);
        repeat (TB_IDLE + 20) @(posedge clk);
        in_line = 0;
        line.delete();
        drain("timeout");
        send_str("K\r", 0);                         drain("after_timeout");

        send_str("+CMT", 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        in_line  = 0;
        line.delete();
        exp_ctrl = 3'b000;
        exp_msg  = 8'h30;
        drain("mid_reset");
        send_str("OK\r", 0);                        drain("ok_after_reset");

        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: add_str("OK");
                1: add_str("ERROR");
                2: add_str("+CPMS: \"SM\",1,30");
                3: begin
                    add_str("+CMTI: \"SM\",");
                    repeat ($urandom_range(0, 2)) pkt.push_back(8'($urandom_range(8'h30, 8'h39)));
                end
                4: begin
                    add_str("AT+CMGR=");
                    pkt.push_back(8'($urandom_range(8'h30, 8'h39)));
                end
                5: begin
                    add_str(">");
                    if ($urandom_range(0, 1) == 1) add_str(" ");
                end
                6: add_junk($urandom_range(1, 8));
                7: begin
                    n = $urandom_range(MAX_LEN - 2, MAX_LEN + 2);
                    add_str("+CPMS:");
                    while (pkt.size() < n) pkt.push_back(8'h78);
                end
                8: case ($urandom_range(0, 8))
                    0: add_str("ok");
                    1: add_str("Ok");
                    2: add_str("OKK");
                    3: add_str("ERRO");
                    4: add_str("ERRORS");
                    5: add_str("+CPMS");
                    6: add_str("+CMTI:");
                    7: add_str("AT");
                    default: add_str("A");
                endcase
                default: add_junk($urandom_range(MAX_LEN - 4, MAX_LEN + 6));
            endcase
            if (kind != 5) begin
                add_str("\r");
                if ($urandom_range(0, 1) == 1) add_str("\n");
            end
            send_pkt($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) pulse_clr();
            drain("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
